// File: rtl/id_redirect.sv
// ============================================================================
//  Module      : id_redirect
//  Description : Decode-side partner of the fetch stage. Holds the IF/ID
//                pipeline register, decodes J/JAL in ID, detects load-use
//                hazards against EX and drives the fetch stage's redirect and
//                stall controls. Keeps saturating stall/flush event counters.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk              in   system clock, rising edge
//    rst_n            in   asynchronous active-low reset
//    irF              in   instruction fetched this cycle
//    pcplusF          in   fetch PC + 4
//    ex_memread       in   instruction in EX is a load
//    ex_rt            in   destination register of the EX load
//    ex_branch_taken  in   branch in EX resolved taken
//    ex_branch_target in   resolved branch target
//    irD / pcplusD    out  IF/ID instruction and PC + 4
//    validD           out  irD holds a real instruction (not a bubble)
//    stall            out  freeze fetch PC and IF/ID
//    jump             out  J/JAL redirect from ID
//    PCSrc            out  taken-branch redirect from EX
//    pcchange         out  redirect target (pcplusF when no redirect)
//    id_kill          out  ID/EX must load a bubble this edge
//    stall_cnt        out  saturating count of stall cycles
//    flush_cnt        out  saturating count of redirect cycles
// ============================================================================
`default_nettype none

module id_redirect #(
  parameter logic [31:0] NOP   = 32'h0000_0000,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      irF,
  input  logic [31:0]      pcplusF,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic [31:0]      ex_branch_target,
  output logic [31:0]      irD,
  output logic [31:0]      pcplusD,
  output logic             validD,
  output logic             stall,
  output logic             jump,
  output logic             PCSrc,
  output logic [31:0]      pcchange,
  output logic             id_kill,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  // IF/ID pipeline register and counters
  logic [31:0]      ir_q, ir_d;
  logic [31:0]      pcplus_q, pcplus_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // ID decode
  logic [5:0] w_op;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic       w_is_j;
  logic       w_rs_used;
  logic       w_rt_used;
  logic       w_haz;

  logic        w_stall;
  logic        w_jump;
  logic        w_pcsrc;
  logic [31:0] w_pcchange;
  logic        w_redirect;

  assign w_op = ir_q[31:26];
  assign w_rs = ir_q[25:21];
  assign w_rt = ir_q[20:16];

  assign w_is_j    = valid_q && ((w_op == 6'h02) || (w_op == 6'h03));
  // J, JAL and LUI carry no rs source operand
  assign w_rs_used = !((w_op == 6'h02) || (w_op == 6'h03) || (w_op == 6'h0F));
  // R-type, BEQ, BNE and SW read rt as a source
  assign w_rt_used = (w_op == 6'h00) || (w_op == 6'h04) ||
                     (w_op == 6'h05) || (w_op == 6'h2B);

  assign w_haz = valid_q && ex_memread && (ex_rt != 5'd0) &&
                 ((w_rs_used && (w_rs == ex_rt)) || (w_rt_used && (w_rt == ex_rt)));

  // Oldest instruction wins: EX branch, then ID hazard, then ID jump.
  always_comb begin
    w_stall    = 1'b0;
    w_jump     = 1'b0;
    w_pcsrc    = 1'b0;
    w_pcchange = pcplusF;
    if (ex_branch_taken) begin
      w_pcsrc    = 1'b1;
      w_pcchange = ex_branch_target;
    end else if (w_haz) begin
      w_stall    = 1'b1;
    end else if (w_is_j) begin
      w_jump     = 1'b1;
      w_pcchange = {pcplus_q[31:28], ir_q[25:0], 2'b00};
    end
  end

  assign w_redirect = w_pcsrc || w_jump;

  always_comb begin
    ir_d        = irF;
    pcplus_d    = pcplusF;
    valid_d     = 1'b1;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (w_redirect) begin
      // wrong-path fetch is dropped; a bubble enters ID
      ir_d    = NOP;
      valid_d = 1'b0;
    end else if (w_stall) begin
      ir_d     = ir_q;
      pcplus_d = pcplus_q;
      valid_d  = valid_q;
    end
    if (w_stall && (stall_cnt_q != c_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + c_CNT_ONE;
    end
    if (w_redirect && (flush_cnt_q != c_CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + c_CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q        <= NOP;
      pcplus_q    <= 32'h0000_0000;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ir_q        <= ir_d;
      pcplus_q    <= pcplus_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign irD       = ir_q;
  assign pcplusD   = pcplus_q;
  assign validD    = valid_q;
  assign stall     = w_stall;
  assign jump      = w_jump;
  assign PCSrc     = w_pcsrc;
  assign pcchange  = w_pcchange;
  assign id_kill   = w_pcsrc || w_stall;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_id_redirect.sv
// ============================================================================
//  Module      : tb_id_redirect
//  Description : Self-checking bench for id_redirect. Stimulus pushes
//                hand-computed expected outputs into a queue; a monitor pops
//                and compares on each falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_redirect;

  logic        clk;
  logic        rst_n;
  logic [31:0] irF;
  logic [31:0] pcplusF;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic [31:0] irD;
  logic [31:0] pcplusD;
  logic        validD;
  logic        stall;
  logic        jump;
  logic        PCSrc;
  logic [31:0] pcchange;
  logic        id_kill;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  id_redirect #(
    .NOP   (32'h0000_0000),
    .CNT_W (16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .irF              (irF),
    .pcplusF          (pcplusF),
    .ex_memread       (ex_memread),
    .ex_rt            (ex_rt),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .irD              (irD),
    .pcplusD          (pcplusD),
    .validD           (validD),
    .stall            (stall),
    .jump             (jump),
    .PCSrc            (PCSrc),
    .pcchange         (pcchange),
    .id_kill          (id_kill),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pcp;
    logic        v;
    logic        st;
    logic        j;
    logic        pcs;
    logic [31:0] chg;
    logic        kill;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec  = 0;
  int    n_fail = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [31:0] ir, input logic [31:0] pcp,
                     input logic mr, input logic [4:0] rt,
                     input logic bt, input logic [31:0] btgt);
    irF              = ir;
    pcplusF          = pcp;
    ex_memread       = mr;
    ex_rt            = rt;
    ex_branch_taken  = bt;
    ex_branch_target = btgt;
  endtask

  task automatic expect_v(input string nm,
                          input logic [31:0] ir, input logic [31:0] pcp,
                          input logic v, input logic st, input logic j,
                          input logic pcs, input logic [31:0] chg,
                          input logic kill, input logic [15:0] sc,
                          input logic [15:0] fc);
    exp_t e;
    e.ir = ir; e.pcp = pcp; e.v = v; e.st = st; e.j = j; e.pcs = pcs;
    e.chg = chg; e.kill = kill; e.sc = sc; e.fc = fc;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: one expectation per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a.ir = irD; a.pcp = pcplusD; a.v = validD; a.st = stall; a.j = jump;
      a.pcs = PCSrc; a.chg = pcchange; a.kill = id_kill;
      a.sc = stall_cnt; a.fc = flush_cnt;
      n_vec = n_vec + 1;
      if (a !== e) begin
        n_fail = n_fail + 1;
        $display("FAIL %s: got ir=%h pcp=%h v=%b st=%b j=%b pcs=%b chg=%h kill=%b sc=%h fc=%h ; want ir=%h pcp=%h v=%b st=%b j=%b pcs=%b chg=%h kill=%b sc=%h fc=%h",
                 nm, a.ir, a.pcp, a.v, a.st, a.j, a.pcs, a.chg, a.kill, a.sc, a.fc,
                 e.ir, e.pcp, e.v, e.st, e.j, e.pcs, e.chg, e.kill, e.sc, e.fc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drv(32'h2008_0001, 32'h4, 1'b0, 5'd0, 1'b0, 32'h0);

    cyc(); expect_v("reset", 32'h0, 32'h0, 0, 0, 0, 0, 32'h4, 0, 16'h0, 16'h0);
    cyc(); rst_n = 1'b1;
    expect_v("reset_release", 32'h0, 32'h0, 0, 0, 0, 0, 32'h4, 0, 16'h0, 16'h0);

    cyc(); drv(32'h0800_0010, 32'h8, 0, 5'd0, 0, 32'h0);
    expect_v("straight_line", 32'h2008_0001, 32'h4, 1, 0, 0, 0, 32'h8, 0, 16'h0, 16'h0);

    cyc(); drv(32'h1111_1111, 32'hC, 0, 5'd0, 0, 32'h0);
    expect_v("jump", 32'h0800_0010, 32'h8, 1, 0, 1, 0, 32'h40, 0, 16'h0, 16'h0);

    cyc(); drv(32'h0109_5020, 32'h44, 0, 5'd0, 0, 32'h0);
    expect_v("jump_flush", 32'h0, 32'hC, 0, 0, 0, 0, 32'h44, 0, 16'h0, 16'h1);

    cyc(); drv(32'h2222_2222, 32'h48, 1, 5'd8, 0, 32'h0);
    expect_v("loaduse_rs", 32'h0109_5020, 32'h44, 1, 1, 0, 0, 32'h48, 1, 16'h0, 16'h1);

    cyc(); drv(32'h2222_2222, 32'h48, 0, 5'd8, 0, 32'h0);
    expect_v("loaduse_release", 32'h0109_5020, 32'h44, 1, 0, 0, 0, 32'h48, 0, 16'h1, 16'h1);

    cyc(); drv(32'h0900_0000, 32'h4C, 1, 5'd0, 0, 32'h0);
    expect_v("no_haz_rt0", 32'h2222_2222, 32'h48, 1, 0, 0, 0, 32'h4C, 0, 16'h1, 16'h1);

    cyc(); drv(32'h3333_3333, 32'h50, 1, 5'd8, 0, 32'h0);
    expect_v("no_haz_jump_rs", 32'h0900_0000, 32'h4C, 1, 0, 1, 0, 32'h0400_0000, 0, 16'h1, 16'h1);

    cyc(); drv(32'h0800_0010, 32'h14, 0, 5'd0, 0, 32'h0);
    expect_v("jump2_flush", 32'h0, 32'h50, 0, 0, 0, 0, 32'h14, 0, 16'h1, 16'h2);

    cyc(); drv(32'h4444_4444, 32'h18, 0, 5'd0, 1, 32'h100);
    expect_v("branch_beats_jump", 32'h0800_0010, 32'h14, 1, 0, 0, 1, 32'h100, 1, 16'h1, 16'h2);

    cyc(); drv(32'h0109_5020, 32'h104, 0, 5'd0, 0, 32'h0);
    expect_v("branch_flush", 32'h0, 32'h18, 0, 0, 0, 0, 32'h104, 0, 16'h1, 16'h3);

    cyc(); drv(32'h5555_5555, 32'h108, 1, 5'd9, 0, 32'h0);
    expect_v("loaduse_rt", 32'h0109_5020, 32'h104, 1, 1, 0, 0, 32'h108, 1, 16'h1, 16'h3);

    // reset asserted between edges while the stall persists
    cyc(); rst_n = 1'b0;
    expect_v("async_reset_mid_stall", 32'h0, 32'h0, 0, 0, 0, 0, 32'h108, 0, 16'h0, 16'h0);

    cyc(); rst_n = 1'b1; drv(32'h0109_5020, 32'h200, 0, 5'd0, 0, 32'h0);
    expect_v("post_reset_idle", 32'h0, 32'h0, 0, 0, 0, 0, 32'h200, 0, 16'h0, 16'h0);

    cyc(); drv(32'h0109_5020, 32'h200, 1, 5'd8, 0, 32'h0);
    expect_v("sat_start", 32'h0109_5020, 32'h200, 1, 1, 0, 0, 32'h200, 1, 16'h0, 16'h0);

    repeat (65534) @(posedge clk);
    cyc();
    expect_v("sat_max", 32'h0109_5020, 32'h200, 1, 1, 0, 0, 32'h200, 1, 16'hFFFF, 16'h0);

    cyc();
    expect_v("sat_hold", 32'h0109_5020, 32'h200, 1, 1, 0, 0, 32'h200, 1, 16'hFFFF, 16'h0);

    cyc(); drv(32'h0109_5020, 32'h200, 1, 5'd8, 1, 32'h300);
    expect_v("branch_over_load", 32'h0109_5020, 32'h200, 1, 0, 0, 1, 32'h300, 1, 16'hFFFF, 16'h0);

    cyc(); drv(32'h0109_5020, 32'h200, 0, 5'd0, 0, 32'h0);
    expect_v("branch_over_load_flush", 32'h0, 32'h200, 0, 0, 0, 0, 32'h200, 0, 16'hFFFF, 16'h1);

    repeat (4) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d expected vectors never checked, want 0", exp_q.size());
      n_fail = n_fail + exp_q.size();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
